n8_button_decoder: RTL and testbench
====================================

# n8_button_decoder

Downstream consumer of the N8/NES serial controller driver. It brings the driver's asynchronously updated, active-low button byte into the system clock domain and debounces it as a whole vector. It then produces active-high held levels, one-cycle press pulses, and a latched movement direction for the Pac-Man game FSM.

## Interface
- `BITS`, default 8: width of the button vector. Must be 8; the bit mapping below is fixed.
- `STABLE_CYCLES`, default 50000: number of consecutive clk edges a new sampled vector must hold before it is committed. Legal range is 1 or more.
- `CNT_W`, default $clog2(STABLE_CYCLES+1): width of the stability counter.

Ports (one clock, `clk`; reset is synchronous and active-high, port `reset`):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `buttons_raw`  in  BITS  driver output.
  - Active-low: 0 means pressed.
  - Asynchronous to clk.
  - Mapping: [7]=A, [6]=B, [5]=Select, [4]=Start, [3]=Up, [2]=Down, [1]=Left, [0]=Right.
- `btn_held`  out  BITS  debounced level, active-high (1 = pressed), same bit mapping.
- `btn_pressed`  out  BITS  one-cycle pulse per bit on each debounced 0→1 transition of btn_held.
- `dir`  out  2  latched direction: 00=Up, 01=Down, 10=Left, 11=Right.
- `dir_valid`  out  1  set on the first direction press after reset, then sticky.
- `dir_change`  out  1  one-cycle pulse when dir is loaded with a new value, or when dir_valid first sets.

## Operation
- **Synchronizer:** two flops, `s1` then `s2`, on each bit. Both reset to all-ones (released), so reset never creates phantom presses.
- **Candidate:** `cand` loads `s2` every edge. Resets to all-ones.
- **Stability counter `cnt`:**
  - If `s2 != cand`, `cnt` is cleared to 0.
  - Otherwise `cnt` increments, saturating at STABLE_CYCLES.
  - Resets to 0.
- **Commit:** on every edge where `cnt == STABLE_CYCLES`, `btn_held` is loaded with `~cand`. This is idempotent while the vector stays stable.
- **Press detect:**
  - `btn_pressed` is registered as (next `btn_held`) & ~(current `btn_held`).
  - It rises in the same cycle that `btn_held` changes.
  - Releases produce no pulse.
  - Several bits may pulse in the same cycle.
- **Direction latch:**
  - Considers `btn_pressed[3:0]` on the cycle it is high.
  - Priority Up > Down > Left > Right when more than one direction pulses together.
  - Loads `dir` and sets `dir_valid`.
  - `dir_change` pulses the following cycle only if the chosen direction differs from the old `dir`, or `dir_valid` was 0.
  - Holding a direction does not re-trigger.
  - Releasing all directions keeps `dir` unchanged. Pac-Man keeps moving.
- A/B/Select/Start affect only `btn_held`/`btn_pressed`; they never affect `dir`.
- **Reset values:**
  - `btn_held` = 0, `btn_pressed` = 0.
  - `dir` = 2'b11, `dir_valid` = 0, `dir_change` = 0.
  - `cnt` = 0.

## Timing
- Let `buttons_raw` change before edge k and then stay stable.
  - `s1` captures it at edge k, `s2` at k+1.
  - At k+2, `cnt` is cleared and `cand` updates.
  - `cnt` reaches STABLE_CYCLES at k+2+S.
  - `btn_held` and `btn_pressed` update at k+3+S. Latency is S+3 edges.
  - `dir`/`dir_valid` update at k+4+S, and `dir_change` is high that cycle.
- Any change in `s2` before `cnt` saturates restarts the count. Glitches shorter than S+1 edges never reach `btn_held`.
- `btn_pressed` and `dir_change` are exactly one cycle wide, with no back-to-back repeats while the level is held.
- Reset mid-debounce discards all state. A button held across reset release yields a press S+3 edges after the first non-reset edge plus the synchronizer fill.
- `buttons_raw` changing on the same edge as `reset` is ignored; the reset values win.

## Test plan
(All scenarios use STABLE_CYCLES=4.)
- **Reset:** assert reset 3 cycles with `buttons_raw`=8'h00 → all outputs at reset values during reset and on the first cycle after release.
- **Clean press:** `buttons_raw` 8'hFF→8'hF7 (Up) at edge k, held → `btn_held`=8'h08 and `btn_pressed`=8'h08 for one cycle at edge k+7; `dir`=00, `dir_valid`=1, `dir_change` pulse at k+8; nothing more while held.
- **Glitch rejection:** `buttons_raw`=8'hFE (Right) for 4 cycles, then back to 8'hFF → `btn_held` stays 0, no pulses. Repeat with 6 cycles → press committed.
- **Simultaneous:** 8'hFF→8'hF3 (Up+Down) → `btn_pressed`=8'h0C, `dir`=00.
  - Then release Up only (8'hFB) → no new `btn_pressed` for Down, `dir` stays 00.
  - Then release and press Down → `dir`=01, `dir_change` pulse.
- **Same direction repeat:** press Left, release, press Left again → second press pulses `btn_pressed[1]` but not `dir_change`. Start press (8'hEF) → `btn_pressed`=8'h10, `dir` unchanged.
- **Reset mid-operation:** assert reset 2 edges after a change to 8'h7F (A) → no press during the reset. After release, with input held, `btn_pressed[7]` fires exactly once.

Source files
------------

// File: rtl/n8_button_decoder.sv
// Button-vector conditioner for the N8/NES controller: synchronizes the active-low
// driver byte, debounces it as a whole, and derives held levels, press pulses and a latched direction.
module n8_button_decoder #(
    parameter int BITS          = 8,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] buttons_raw,
    output logic [BITS-1:0] btn_held,
    output logic [BITS-1:0] btn_pressed,
    output logic [1:0]      dir,
    output logic            dir_valid,
    output logic            dir_change
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    logic [BITS-1:0]  s1_q, s1_d;
    logic [BITS-1:0]  s2_q, s2_d;
    logic [BITS-1:0]  cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BITS-1:0]  held_q, held_d;
    logic [BITS-1:0]  pressed_q, pressed_d;
    logic [1:0]       dir_q, dir_d;
    logic             dir_valid_q, dir_valid_d;
    logic             dir_change_q, dir_change_d;

    logic             commit;
    logic             dir_hit;
    logic [1:0]       dir_pick;

    always_comb begin
        s1_d   = buttons_raw;
        s2_d   = s1_q;
        cand_d = s2_q;

        // Any movement of the synchronized vector restarts the stability window.
        if (s2_q != cand_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        commit    = (cnt_q == CNT_MAX);
        held_d    = commit ? ~cand_q : held_q;
        pressed_d = held_d & ~held_q;

        // Up > Down > Left > Right when several directions pulse together.
        dir_hit = |pressed_q[3:0];
        if (pressed_q[3]) begin
            dir_pick = DIR_UP;
        end else if (pressed_q[2]) begin
            dir_pick = DIR_DOWN;
        end else if (pressed_q[1]) begin
            dir_pick = DIR_LEFT;
        end else begin
            dir_pick = DIR_RIGHT;
        end

        dir_d        = dir_hit ? dir_pick : dir_q;
        dir_valid_d  = dir_valid_q | dir_hit;
        dir_change_d = dir_hit && (!dir_valid_q || (dir_pick != dir_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q         <= '1;
            s2_q         <= '1;
            cand_q       <= '1;
            cnt_q        <= '0;
            held_q       <= '0;
            pressed_q    <= '0;
            dir_q        <= DIR_RIGHT;
            dir_valid_q  <= 1'b0;
            dir_change_q <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            held_q       <= held_d;
            pressed_q    <= pressed_d;
            dir_q        <= dir_d;
            dir_valid_q  <= dir_valid_d;
            dir_change_q <= dir_change_d;
        end
    end

    assign btn_held    = held_q;
    assign btn_pressed = pressed_q;
    assign dir         = dir_q;
    assign dir_valid   = dir_valid_q;
    assign dir_change  = dir_change_q;

endmodule

// File: tb/tb_n8_button_decoder.sv
// Directed bench for n8_button_decoder with a short debounce window (4 edges).
module tb_n8_button_decoder;

    localparam int BITS = 8;
    localparam int S    = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [BITS-1:0] buttons_raw;
    logic [BITS-1:0] btn_held;
    logic [BITS-1:0] btn_pressed;
    logic [1:0]      dir;
    logic            dir_valid;
    logic            dir_change;

    int checks = 0;
    int errors = 0;

    n8_button_decoder #(
        .BITS(BITS),
        .STABLE_CYCLES(S)
    ) dut (
        .clk(clk),
        .reset(reset),
        .buttons_raw(buttons_raw),
        .btn_held(btn_held),
        .btn_pressed(btn_pressed),
        .dir(dir),
        .dir_valid(dir_valid),
        .dir_change(dir_change)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        buttons_raw = 8'hFF;
        tick(3);
        reset = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        buttons_raw = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checks++;
            if (btn_held !== 8'h00 || btn_pressed !== 8'h00) begin
                errors++;
                $display("FAIL reset_btns cycle %0d held %h pressed %h exp 00 00", i, btn_held, btn_pressed);
            end
            checks++;
            if (dir !== 2'b11 || dir_valid !== 1'b0 || dir_change !== 1'b0) begin
                errors++;
                $display("FAIL reset_dir cycle %0d dir %b valid %b change %b exp 11 0 0", i, dir, dir_valid, dir_change);
            end
        end
        reset = 1'b0;
        tick(1);
        checks++;
        if (btn_held !== 8'h00 || btn_pressed !== 8'h00 || dir !== 2'b11 || dir_valid !== 1'b0 || dir_change !== 1'b0) begin
            errors++;
            $display("FAIL reset_release held %h pressed %h dir %b valid %b change %b exp 00 00 11 0 0",
                     btn_held, btn_pressed, dir, dir_valid, dir_change);
        end
        do_reset();
    endtask

    task automatic test_clean_press();
        buttons_raw = 8'hF7;
        tick(7);
        checks++;
        if (btn_held !== 8'h00 || btn_pressed !== 8'h00) begin
            errors++;
            $display("FAIL clean_early held %h pressed %h exp 00 00", btn_held, btn_pressed);
        end
        tick(1);
        checks++;
        if (btn_held !== 8'h08 || btn_pressed !== 8'h08) begin
            errors++;
            $display("FAIL clean_commit held %h pressed %h exp 08 08", btn_held, btn_pressed);
        end
        checks++;
        if (dir_valid !== 1'b0 || dir_change !== 1'b0) begin
            errors++;
            $display("FAIL clean_dir_early valid %b change %b exp 0 0", dir_valid, dir_change);
        end
        tick(1);
        checks++;
        if (btn_pressed !== 8'h00 || dir !== 2'b00 || dir_valid !== 1'b1 || dir_change !== 1'b1) begin
            errors++;
            $display("FAIL clean_dir pressed %h dir %b valid %b change %b exp 00 00 1 1",
                     btn_pressed, dir, dir_valid, dir_change);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++;
            if (btn_held !== 8'h08 || btn_pressed !== 8'h00 || dir_change !== 1'b0) begin
                errors++;
                $display("FAIL clean_hold cycle %0d held %h pressed %h change %b exp 08 00 0",
                         i, btn_held, btn_pressed, dir_change);
            end
        end
        buttons_raw = 8'hFF;
        tick(8);
        checks++;
        if (btn_held !== 8'h00 || btn_pressed !== 8'h00 || dir !== 2'b00) begin
            errors++;
            $display("FAIL clean_release held %h pressed %h dir %b exp 00 00 00", btn_held, btn_pressed, dir);
        end
        tick(2);
    endtask

    task automatic test_glitch();
        buttons_raw = 8'hFE;
        tick(4);
        buttons_raw = 8'hFF;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            checks++;
            if (btn_held !== 8'h00 || btn_pressed !== 8'h00) begin
                errors++;
                $display("FAIL glitch_reject cycle %0d held %h pressed %h exp 00 00", i, btn_held, btn_pressed);
            end
        end
        buttons_raw = 8'hFE;
        tick(6);
        buttons_raw = 8'hFF;
        tick(2);
        checks++;
        if (btn_held !== 8'h01 || btn_pressed !== 8'h01) begin
            errors++;
            $display("FAIL glitch_commit held %h pressed %h exp 01 01", btn_held, btn_pressed);
        end
        tick(1);
        checks++;
        if (dir !== 2'b11 || dir_change !== 1'b1) begin
            errors++;
            $display("FAIL glitch_dir dir %b change %b exp 11 1", dir, dir_change);
        end
        tick(8);
        checks++;
        if (btn_held !== 8'h00 || btn_pressed !== 8'h00) begin
            errors++;
            $display("FAIL glitch_release held %h pressed %h exp 00 00", btn_held, btn_pressed);
        end
    endtask

    task automatic test_simultaneous();
        buttons_raw = 8'hF3;
        tick(8);
        checks++;
        if (btn_held !== 8'h0C || btn_pressed !== 8'h0C) begin
            errors++;
            $display("FAIL simul_press held %h pressed %h exp 0c 0c", btn_held, btn_pressed);
        end
        tick(1);
        checks++;
        if (dir !== 2'b00 || dir_change !== 1'b1) begin
            errors++;
            $display("FAIL simul_dir dir %b change %b exp 00 1", dir, dir_change);
        end
        tick(2);
        buttons_raw = 8'hFB;
        tick(8);
        checks++;
        if (btn_held !== 8'h04 || btn_pressed !== 8'h00) begin
            errors++;
            $display("FAIL simul_up_release held %h pressed %h exp 04 00", btn_held, btn_pressed);
        end
        tick(1);
        checks++;
        if (dir !== 2'b00 || dir_change !== 1'b0) begin
            errors++;
            $display("FAIL simul_keep_dir dir %b change %b exp 00 0", dir, dir_change);
        end
        buttons_raw = 8'hFF;
        tick(10);
        buttons_raw = 8'hFB;
        tick(8);
        checks++;
        if (btn_held !== 8'h04 || btn_pressed !== 8'h04) begin
            errors++;
            $display("FAIL simul_down_press held %h pressed %h exp 04 04", btn_held, btn_pressed);
        end
        tick(1);
        checks++;
        if (dir !== 2'b01 || dir_change !== 1'b1) begin
            errors++;
            $display("FAIL simul_down_dir dir %b change %b exp 01 1", dir, dir_change);
        end
        buttons_raw = 8'hFF;
        tick(10);
    endtask

    task automatic test_same_dir();
        buttons_raw = 8'hFD;
        tick(8);
        checks++;
        if (btn_pressed !== 8'h02) begin
            errors++;
            $display("FAIL left1_press pressed %h exp 02", btn_pressed);
        end
        tick(1);
        checks++;
        if (dir !== 2'b10 || dir_change !== 1'b1) begin
            errors++;
            $display("FAIL left1_dir dir %b change %b exp 10 1", dir, dir_change);
        end
        buttons_raw = 8'hFF;
        tick(10);
        buttons_raw = 8'hFD;
        tick(8);
        checks++;
        if (btn_pressed !== 8'h02) begin
            errors++;
            $display("FAIL left2_press pressed %h exp 02", btn_pressed);
        end
        tick(1);
        checks++;
        if (dir !== 2'b10 || dir_change !== 1'b0) begin
            errors++;
            $display("FAIL left2_dir dir %b change %b exp 10 0", dir, dir_change);
        end
        buttons_raw = 8'hFF;
        tick(10);
        buttons_raw = 8'hEF;
        tick(8);
        checks++;
        if (btn_held !== 8'h10 || btn_pressed !== 8'h10) begin
            errors++;
            $display("FAIL start_press held %h pressed %h exp 10 10", btn_held, btn_pressed);
        end
        tick(1);
        checks++;
        if (dir !== 2'b10 || dir_change !== 1'b0 || btn_pressed !== 8'h00) begin
            errors++;
            $display("FAIL start_dir dir %b change %b pressed %h exp 10 0 00", dir, dir_change, btn_pressed);
        end
        buttons_raw = 8'hFF;
        tick(10);
    endtask

    task automatic test_reset_mid();
        int pulses;
        int pulse_at;
        buttons_raw = 8'h7F;
        tick(2);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checks++;
            if (btn_held !== 8'h00 || btn_pressed !== 8'h00 || dir !== 2'b11 || dir_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_during cycle %0d held %h pressed %h dir %b valid %b exp 00 00 11 0",
                         i, btn_held, btn_pressed, dir, dir_valid);
            end
        end
        reset = 1'b0;
        pulses = 0;
        pulse_at = -1;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (btn_pressed[7] === 1'b1) begin
                pulses++;
                pulse_at = i;
            end
        end
        checks++;
        if (pulses != 1 || pulse_at != 8) begin
            errors++;
            $display("FAIL rstmid_pulse count %0d at %0d exp 1 at 8", pulses, pulse_at);
        end
        checks++;
        if (btn_held !== 8'h80 || dir !== 2'b11 || dir_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_final held %h dir %b valid %b exp 80 11 0", btn_held, dir, dir_valid);
        end
        buttons_raw = 8'hFF;
        tick(10);
    endtask

    initial begin
        reset = 1'b1;
        buttons_raw = 8'hFF;
        tick(1);
        test_reset();
        test_clean_press();
        test_glitch();
        test_simultaneous();
        test_same_dir();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
